// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common data bus arbiter for an out-of-order core.
// Each producer channel feeds a small FIFO of {dest, value, pc} results.
// Every cycle one non-empty channel is chosen round-robin and its head entry
// is broadcast on the registered cdb_* outputs. Consumers never stall the bus.
module cdb_arbiter #(
  parameter int NUM_SRC      = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int ROB_ID_WIDTH = 4,
  parameter int XLEN         = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [NUM_SRC-1:0]              src_valid,
  output logic [NUM_SRC-1:0]              src_ready,
  input  logic [NUM_SRC*ROB_ID_WIDTH-1:0] src_dest,
  input  logic [NUM_SRC*XLEN-1:0]         src_value,
  input  logic [NUM_SRC*XLEN-1:0]         src_pc,
  output logic                            cdb_valid,
  output logic [ROB_ID_WIDTH-1:0]         cdb_dest,
  output logic [XLEN-1:0]                 cdb_value,
  output logic [XLEN-1:0]                 cdb_pc,
  output logic [$clog2(NUM_SRC)-1:0]      cdb_src
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = ROB_ID_WIDTH + 2 * XLEN;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(NUM_SRC - 1);

  // Per-channel storage and bookkeeping
  logic [ENT_W-1:0]        mem_r    [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r [NUM_SRC];
  logic [PTR_W-1:0]        rd_ptr_r [NUM_SRC];
  logic [CNT_W-1:0]        count_r  [NUM_SRC];

  // Arbitration state and broadcast registers
  logic [SRC_W-1:0]        rr_ptr_r;
  logic                    cdb_valid_r;
  logic [ROB_ID_WIDTH-1:0] cdb_dest_r;
  logic [XLEN-1:0]         cdb_value_r;
  logic [XLEN-1:0]         cdb_pc_r;
  logic [SRC_W-1:0]        cdb_src_r;

  // Combinational helpers
  logic [NUM_SRC-1:0]      ready_s;
  logic [NUM_SRC-1:0]      nonempty_s;
  logic [NUM_SRC-1:0]      push_s;
  logic [NUM_SRC-1:0]      pop_s;
  logic                    grant_s;
  logic [SRC_W-1:0]        winner_s;
  logic [SRC_W-1:0]        next_rr_s;
  logic [ENT_W-1:0]        win_ent_s;

  // Channel status: ready/non-empty come purely from the registered counts
  always_comb begin
    ready_s    = {NUM_SRC{1'b0}};
    nonempty_s = {NUM_SRC{1'b0}};
    push_s     = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      ready_s[i]    = (count_r[i] != FULL_CNT);
      nonempty_s[i] = (count_r[i] != {CNT_W{1'b0}});
      push_s[i]     = src_valid[i] & ready_s[i] & ~flush;
    end
  end

  assign src_ready = ready_s;

  // Round-robin search for the first non-empty channel at or after rr_ptr
  always_comb begin
    int               sum;
    logic [SRC_W-1:0] cand;
    grant_s  = 1'b0;
    winner_s = {SRC_W{1'b0}};
    sum      = 0;
    cand     = {SRC_W{1'b0}};
    for (int k = 0; k < NUM_SRC; k++) begin
      sum = int'(rr_ptr_r) + k;
      if (sum >= NUM_SRC) begin
        sum = sum - NUM_SRC;
      end else begin
        sum = sum;
      end
      cand = SRC_W'(sum);
      if (!grant_s && nonempty_s[cand]) begin
        grant_s  = 1'b1;
        winner_s = cand;
      end else begin
        grant_s  = grant_s;
        winner_s = winner_s;
      end
    end
  end

  // Winner's head entry, pop strobes and the post-grant priority pointer
  always_comb begin
    pop_s     = {NUM_SRC{1'b0}};
    win_ent_s = mem_r[winner_s][rd_ptr_r[winner_s]];
    for (int i = 0; i < NUM_SRC; i++) begin
      pop_s[i] = grant_s & ~flush & (winner_s == SRC_W'(i));
    end
    if (winner_s == LAST_SRC) begin
      next_rr_s = {SRC_W{1'b0}};
    end else begin
      next_rr_s = winner_s + SRC_W'(1);
    end
  end

  // FIFO payload storage; contents are only meaningful below the count
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push_s[i]) begin
        mem_r[i][wr_ptr_r[i]] <= {src_dest[i*ROB_ID_WIDTH +: ROB_ID_WIDTH],
                                  src_value[i*XLEN +: XLEN],
                                  src_pc[i*XLEN +: XLEN]};
      end
    end
  end

  // FIFO pointers and occupancy; flush empties every channel at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr_r[i] <= {PTR_W{1'b0}};
        rd_ptr_r[i] <= {PTR_W{1'b0}};
        count_r[i]  <= {CNT_W{1'b0}};
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr_r[i] <= {PTR_W{1'b0}};
        rd_ptr_r[i] <= {PTR_W{1'b0}};
        count_r[i]  <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push_s[i]) begin
          wr_ptr_r[i] <= wr_ptr_r[i] + PTR_W'(1);
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
        end
        case ({push_s[i], pop_s[i]})
          2'b10:   count_r[i] <= count_r[i] + CNT_W'(1);
          2'b01:   count_r[i] <= count_r[i] - CNT_W'(1);
          default: count_r[i] <= count_r[i];
        endcase
      end
    end
  end

  // Broadcast registers and priority pointer; idle cycles hold the last payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_r <= 1'b0;
      cdb_dest_r  <= {ROB_ID_WIDTH{1'b0}};
      cdb_value_r <= {XLEN{1'b0}};
      cdb_pc_r    <= {XLEN{1'b0}};
      cdb_src_r   <= {SRC_W{1'b0}};
      rr_ptr_r    <= {SRC_W{1'b0}};
    end else if (flush) begin
      cdb_valid_r <= 1'b0;
    end else if (grant_s) begin
      cdb_valid_r <= 1'b1;
      {cdb_dest_r, cdb_value_r, cdb_pc_r} <= win_ent_s;
      cdb_src_r   <= winner_s;
      rr_ptr_r    <= next_rr_s;
    end else begin
      cdb_valid_r <= 1'b0;
    end
  end

  assign cdb_valid = cdb_valid_r;
  assign cdb_dest  = cdb_dest_r;
  assign cdb_value = cdb_value_r;
  assign cdb_pc    = cdb_pc_r;
  assign cdb_src   = cdb_src_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter (4 channels): table-driven vectors plus a
// behavioural scoreboard model and hand-written multi-cycle sequences.
module tb_cdb_arbiter;
  localparam int NS = 4;
  localparam int FD = 4;
  localparam int RW = 4;
  localparam int XL = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [NS-1:0]     src_valid;
  logic [NS-1:0]     src_ready;
  logic [NS*RW-1:0]  src_dest;
  logic [NS*XL-1:0]  src_value;
  logic [NS*XL-1:0]  src_pc;
  logic              cdb_valid;
  logic [RW-1:0]     cdb_dest;
  logic [XL-1:0]     cdb_value;
  logic [XL-1:0]     cdb_pc;
  logic [1:0]        cdb_src;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_SRC(NS), .FIFO_DEPTH(FD), .ROB_ID_WIDTH(RW), .XLEN(XL)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_dest(src_dest), .src_value(src_value), .src_pc(src_pc),
    .cdb_valid(cdb_valid), .cdb_dest(cdb_dest), .cdb_value(cdb_value),
    .cdb_pc(cdb_pc), .cdb_src(cdb_src)
  );

  typedef struct packed {
    logic [RW-1:0] dest;
    logic [XL-1:0] value;
    logic [XL-1:0] pc;
  } ent_t;

  typedef struct packed {
    logic          v;
    logic [1:0]    src;
    ent_t          e;
    logic [NS-1:0] rdy;
  } exp_t;

  typedef struct packed {
    logic          fl;
    logic [NS-1:0] v;
    logic          ev;
    logic [1:0]    es;
    logic [NS-1:0] er;
  } vec_t;

  ent_t mq [NS][$];
  exp_t exp_q [$];
  exp_t mcdb;
  int   mrr;
  int   nvec = 0;
  int   nerr = 0;
  int   seq  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic ent_t get_ent(input int i);
    ent_t e;
    e.dest  = src_dest[i*RW +: RW];
    e.value = src_value[i*XL +: XL];
    e.pc    = src_pc[i*XL +: XL];
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) mq[i].delete();
    exp_q.delete();
    mcdb = '0;
    mrr  = 0;
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_step();
    exp_t          x;
    logic [NS-1:0] rdy_before;
    int            w;
    int            c;
    for (int i = 0; i < NS; i++) rdy_before[i] = (mq[i].size() != FD);
    if (flush) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      mcdb.v = 1'b0;
    end else begin
      w = -1;
      for (int k = 0; k < NS; k++) begin
        c = (mrr + k) % NS;
        if (w < 0 && mq[c].size() != 0) w = c;
      end
      if (w >= 0) begin
        mcdb.v   = 1'b1;
        mcdb.src = 2'(w);
        mcdb.e   = mq[w].pop_front();
        mrr      = (w + 1) % NS;
      end else begin
        mcdb.v = 1'b0;
      end
      for (int i = 0; i < NS; i++)
        if (src_valid[i] && rdy_before[i]) mq[i].push_back(get_ent(i));
    end
    x = mcdb;
    for (int i = 0; i < NS; i++) x.rdy[i] = (mq[i].size() != FD);
    exp_q.push_back(x);
  endtask

  // One clock: predict, clock, then compare DUT against the scoreboard.
  task automatic tick();
    exp_t x;
    model_step();
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    nvec++;
    if (cdb_valid !== x.v || src_ready !== x.rdy ||
        {cdb_src, cdb_dest, cdb_value, cdb_pc} !== {x.src, x.e}) begin
      nerr++;
      $display("FAIL scoreboard: got v=%b src=%0d dest=%h val=%h pc=%h rdy=%b, expected v=%b src=%0d dest=%h val=%h pc=%h rdy=%b",
               cdb_valid, cdb_src, cdb_dest, cdb_value, cdb_pc, src_ready,
               x.v, x.src, x.e.dest, x.e.value, x.e.pc, x.rdy);
    end
  endtask

  task automatic drive(input logic fl, input logic [NS-1:0] v);
    flush     = fl;
    src_valid = v;
    for (int i = 0; i < NS; i++) begin
      if (v[i]) begin
        src_dest[i*RW +: RW]  = 4'(seq);
        src_value[i*XL +: XL] = 32'hC0DE_0000 + 32'(seq);
        src_pc[i*XL +: XL]    = 32'h0000_1000 + 32'(seq * 4);
        seq++;
      end
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    flush     = 1'b0;
    src_valid = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [11];
    int   wins [NS];
    int   last;
    int   rep;
    logic full_seen;

    tbl[0]  = '{1'b0, 4'b0011, 1'b0, 2'd0, 4'hF};
    tbl[1]  = '{1'b0, 4'b0011, 1'b1, 2'd0, 4'hF};
    tbl[2]  = '{1'b0, 4'b0000, 1'b1, 2'd1, 4'hF};
    tbl[3]  = '{1'b0, 4'b0000, 1'b1, 2'd0, 4'hF};
    tbl[4]  = '{1'b0, 4'b0000, 1'b1, 2'd1, 4'hF};
    tbl[5]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 4'hF};
    tbl[6]  = '{1'b0, 4'b1100, 1'b0, 2'd0, 4'hF};
    tbl[7]  = '{1'b0, 4'b0000, 1'b1, 2'd2, 4'hF};
    tbl[8]  = '{1'b0, 4'b0001, 1'b1, 2'd3, 4'hF};
    tbl[9]  = '{1'b0, 4'b0000, 1'b1, 2'd0, 4'hF};
    tbl[10] = '{1'b0, 4'b0000, 1'b0, 2'd0, 4'hF};

    rst_n = 1'b1; flush = 1'b0; src_valid = '0;
    src_dest = '0; src_value = '0; src_pc = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("reset_valid", 128'(cdb_valid), 128'(0));
    chk("reset_data", 128'({cdb_src, cdb_dest, cdb_value, cdb_pc}), 128'(0));
    chk("reset_ready", 128'(src_ready), 128'(4'hF));
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single push with one-cycle latency
    src_valid = 4'b0001;
    src_dest[3:0] = 4'd3; src_value[31:0] = 32'hDEAD_BEEF; src_pc[31:0] = 32'h0000_0100;
    tick();
    chk("single_before", 128'(cdb_valid), 128'(0));
    src_valid = '0;
    tick();
    chk("single_valid", 128'(cdb_valid), 128'(1));
    chk("single_dest", 128'(cdb_dest), 128'(4'd3));
    chk("single_value", 128'(cdb_value), 128'(32'hDEAD_BEEF));
    chk("single_pc", 128'(cdb_pc), 128'(32'h0000_0100));
    chk("single_src", 128'(cdb_src), 128'(2'd0));
    tick();
    chk("single_after", 128'(cdb_valid), 128'(0));

    // Round-robin vectors from a fresh reset
    do_reset();
    for (int r = 0; r < 11; r++) begin
      drive(tbl[r].fl, tbl[r].v);
      tick();
      chk("tbl_valid", 128'(cdb_valid), 128'(tbl[r].ev));
      if (tbl[r].ev) chk("tbl_src", 128'(cdb_src), 128'(tbl[r].es));
      chk("tbl_ready", 128'(src_ready), 128'(tbl[r].er));
    end

    // Saturate every channel so ch1 fills up and extra offers get dropped
    full_seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 4'b1111);
      tick();
      if (src_ready[1] === 1'b0) full_seen = 1'b1;
    end
    chk("full_ch1_seen", 128'(full_seen), 128'(1));
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 4'b0000);
      tick();
    end
    chk("drain_idle", 128'(cdb_valid), 128'(0));

    // Flush with buffered entries and a concurrent push
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 4'b0011);
      tick();
    end
    drive(1'b0, 4'b0001);
    tick();
    drive(1'b1, 4'b0001);
    tick();
    chk("flush_valid", 128'(cdb_valid), 128'(0));
    chk("flush_ready", 128'(src_ready), 128'(4'hF));
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 4'b0000);
      tick();
      chk("flush_no_stale", 128'(cdb_valid), 128'(0));
    end

    // Asynchronous reset while a broadcast is on the bus
    drive(1'b0, 4'b0100);
    tick();
    drive(1'b0, 4'b0100);
    tick();
    chk("pre_reset_valid", 128'(cdb_valid), 128'(1));
    drive(1'b0, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 128'(cdb_valid), 128'(0));
    chk("async_data", 128'({cdb_src, cdb_dest, cdb_value, cdb_pc}), 128'(0));
    chk("async_ready", 128'(src_ready), 128'(4'hF));
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    tick();
    chk("post_reset_idle", 128'(cdb_valid), 128'(0));
    drive(1'b0, 4'b1010);
    tick();
    drive(1'b0, 4'b0000);
    tick();
    chk("post_reset_src", 128'(cdb_src), 128'(2'd1));
    tick();
    chk("post_reset_src2", 128'(cdb_src), 128'(2'd3));

    // Fairness: all channels continuously non-empty for 40 cycles
    drive(1'b0, 4'b1111);
    tick();
    for (int i = 0; i < NS; i++) wins[i] = 0;
    last = -1;
    rep  = 0;
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, 4'b1111);
      tick();
      if (cdb_valid === 1'b1) begin
        wins[cdb_src]++;
        if (int'(cdb_src) == last) rep++;
        last = int'(cdb_src);
      end
    end
    for (int i = 0; i < NS; i++) chk("fair_wins", 128'(wins[i]), 128'(10));
    chk("fair_no_repeat", 128'(rep), 128'(0));
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 4'b0000);
      tick();
    end
    chk("final_idle", 128'(cdb_valid), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
